// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite master: one cmd -> one AXI-Lite txn -> one rsp; write rsp 3 cycles after accept at best.
// Backpressure: cmd_ready stays low from accept until the response is taken; rsp payload holds until rsp_ready.
module axil_cmd_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_timeout,
   output logic [ADDR_WIDTH-1:0] m_awaddr,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [DATA_WIDTH-1:0] m_wdata,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic [1:0]            m_bresp,
   input  logic                  m_bvalid,
   output logic                  m_bready,
   output logic [ADDR_WIDTH-1:0] m_araddr,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic                  m_rvalid,
   output logic                  m_rready
);

   localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit            TO_EN    = (TIMEOUT > 0);

   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

   state_t                state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  bready_q, bready_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_write_q, rsp_write_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]            rsp_resp_q, rsp_resp_d;
   logic                  rsp_timeout_q, rsp_timeout_d;

   always_comb begin
      state_d       = state_q;
      cmd_ready_d   = cmd_ready_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      cnt_d         = cnt_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_write_d   = rsp_write_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_timeout_d = rsp_timeout_q;
      case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               addr_d      = cmd_addr;
               wdata_d     = cmd_wdata;
               rsp_write_d = cmd_write;
               if (cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_AW_W;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_AR;
               end
            end
         end
         WR_AW_W: begin
            // Each channel retires on its own handshake and is never re-raised.
            if (awvalid_q && m_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               cnt_d    = '0;
               state_d  = WR_B;
            end
         end
         WR_B: begin
            if (m_bvalid && bready_q) begin
               bready_d      = 1'b0;
               rsp_resp_d    = m_bresp;
               rsp_rdata_d   = '0;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = RSP;
            end else if (TO_EN && cnt_q == CNT_LAST) begin
               bready_d      = 1'b0;
               rsp_resp_d    = 2'b10;
               rsp_rdata_d   = '0;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               state_d       = RSP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RD_AR: begin
            if (m_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               cnt_d     = '0;
               state_d   = RD_R;
            end
         end
         RD_R: begin
            if (m_rvalid && rready_q) begin
               rready_d      = 1'b0;
               rsp_resp_d    = m_rresp;
               rsp_rdata_d   = m_rdata;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = RSP;
            end else if (TO_EN && cnt_q == CNT_LAST) begin
               rready_d      = 1'b0;
               rsp_resp_d    = 2'b10;
               rsp_rdata_d   = '0;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               state_d       = RSP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         cnt_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_write_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_resp_q    <= 2'b00;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         cnt_q         <= cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_write_q   <= rsp_write_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_write   = rsp_write_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_resp    = rsp_resp_q;
   assign rsp_timeout = rsp_timeout_q;
   assign m_awaddr    = addr_q;
   assign m_awvalid   = awvalid_q;
   assign m_wdata     = wdata_q;
   assign m_wvalid    = wvalid_q;
   assign m_bready    = bready_q;
   assign m_araddr    = addr_q;
   assign m_arvalid   = arvalid_q;
   assign m_rready    = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master (TIMEOUT=16); inputs driven and outputs sampled on the falling edge.
module tb_axil_cmd_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic        m_awvalid, m_awready, m_wvalid, m_wready;
   logic [1:0]  m_bresp, m_rresp;
   logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

   int checks = 0;
   int errors = 0;
   int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
   logic [31:0] last_awaddr = '0, last_wdata = '0;
   int bad;

   always #5 clk = ~clk;

   axil_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
      .clk(clk), .reset(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   always @(posedge clk) begin
      if (m_awvalid && m_awready) begin aw_hs++; last_awaddr = m_awaddr; end
      if (m_wvalid && m_wready)   begin w_hs++;  last_wdata  = m_wdata;  end
      if (m_bvalid && m_bready)   b_hs++;
      if (m_arvalid && m_arready) ar_hs++;
      if (m_rvalid && m_rready)   r_hs++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1;
      m_awready = 1; m_wready = 1; m_arready = 1;
      m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rresp = 0; m_rdata = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_awvalid", m_awvalid, 0);
      chk("rst_wvalid", m_wvalid, 0);
      chk("rst_arvalid", m_arvalid, 0);
      chk("rst_bready", m_bready, 0);
      chk("rst_rready", m_rready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_awaddr", m_awaddr, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      rst = 1'b0;

      // 1: write 0x10 <- DEADBEEF, slave always ready
      @(negedge clk);
      chk("t1_idle_cmd_ready", cmd_ready, 1);
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF;
      @(negedge clk);
      cmd_valid = 0;
      chk("t1_awvalid", m_awvalid, 1);
      chk("t1_wvalid", m_wvalid, 1);
      chk("t1_awaddr", m_awaddr, 32'h10);
      chk("t1_wdata", m_wdata, 32'hDEADBEEF);
      chk("t1_cmd_ready_busy", cmd_ready, 0);
      @(negedge clk);
      chk("t1_awvalid_drop", m_awvalid, 0);
      chk("t1_wvalid_drop", m_wvalid, 0);
      chk("t1_bready", m_bready, 1);
      chk("t1_rsp_not_yet", rsp_valid, 0);
      m_bvalid = 1; m_bresp = 2'b00;
      @(negedge clk);
      m_bvalid = 0;
      chk("t1_rsp_valid", rsp_valid, 1);
      chk("t1_rsp_write", rsp_write, 1);
      chk("t1_rsp_resp", rsp_resp, 0);
      chk("t1_rsp_rdata", rsp_rdata, 0);
      chk("t1_rsp_timeout", rsp_timeout, 0);
      @(negedge clk);
      chk("t1_rsp_taken", rsp_valid, 0);
      chk("t1_cmd_ready_back", cmd_ready, 1);
      chk("t1_aw_hs", aw_hs, 1);
      chk("t1_w_hs", w_hs, 1);
      chk("t1_b_hs", b_hs, 1);
      chk("t1_hs_awaddr", last_awaddr, 32'h10);
      chk("t1_hs_wdata", last_wdata, 32'hDEADBEEF);

      // 2: read 0x10, rvalid 2 cycles after AR handshake
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h10; cmd_wdata = '0;
      @(negedge clk);
      cmd_valid = 0;
      chk("t2_arvalid", m_arvalid, 1);
      chk("t2_araddr", m_araddr, 32'h10);
      chk("t2_no_awvalid", m_awvalid, 0);
      @(negedge clk);
      chk("t2_arvalid_drop", m_arvalid, 0);
      chk("t2_rready", m_rready, 1);
      @(negedge clk);
      chk("t2_rsp_not_yet", rsp_valid, 0);
      m_rvalid = 1; m_rdata = 32'hDEADBEEF; m_rresp = 2'b00;
      @(negedge clk);
      m_rvalid = 0;
      chk("t2_rsp_valid", rsp_valid, 1);
      chk("t2_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("t2_rsp_resp", rsp_resp, 0);
      chk("t2_rsp_timeout", rsp_timeout, 0);
      chk("t2_rsp_write", rsp_write, 0);
      chk("t2_rready_drop", m_rready, 0);
      @(negedge clk);
      chk("t2_rsp_taken", rsp_valid, 0);
      chk("t2_ar_hs", ar_hs, 1);
      chk("t2_r_hs", r_hs, 1);

      // 3: write, wready 4 cycles after awready
      m_wready = 0;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h24; cmd_wdata = 32'h12345678;
      @(negedge clk);
      cmd_valid = 0;
      chk("t3_awvalid", m_awvalid, 1);
      chk("t3_wvalid", m_wvalid, 1);
      @(negedge clk);
      chk("t3_awvalid_drop", m_awvalid, 0);
      chk("t3_wvalid_held", m_wvalid, 1);
      chk("t3_wdata_stable", m_wdata, 32'h12345678);
      repeat (2) @(negedge clk);
      chk("t3_wvalid_held2", m_wvalid, 1);
      chk("t3_no_bready", m_bready, 0);
      @(negedge clk);
      chk("t3_wvalid_held3", m_wvalid, 1);
      chk("t3_awvalid_low", m_awvalid, 0);
      m_wready = 1;
      @(negedge clk);
      chk("t3_wvalid_drop", m_wvalid, 0);
      chk("t3_bready", m_bready, 1);
      m_bvalid = 1; m_bresp = 2'b01;
      @(negedge clk);
      m_bvalid = 0;
      chk("t3_rsp_valid", rsp_valid, 1);
      chk("t3_rsp_resp", rsp_resp, 2'b01);
      chk("t3_rsp_write", rsp_write, 1);
      @(negedge clk);
      chk("t3_aw_hs", aw_hs, 2);
      chk("t3_w_hs", w_hs, 2);
      chk("t3_b_hs", b_hs, 2);
      chk("t3_hs_awaddr", last_awaddr, 32'h24);
      chk("t3_hs_wdata", last_wdata, 32'h12345678);

      // 4: read with no rvalid -> timeout after 16 waiting cycles
      rsp_ready = 0;
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h30;
      @(negedge clk);
      cmd_valid = 0;
      chk("t4_arvalid", m_arvalid, 1);
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (rsp_valid !== 1'b0 || m_rready !== 1'b1) bad++;
         @(negedge clk);
      end
      chk("t4_wait_window", bad, 0);
      chk("t4_rsp_valid", rsp_valid, 1);
      chk("t4_rsp_timeout", rsp_timeout, 1);
      chk("t4_rsp_resp", rsp_resp, 2'b10);
      chk("t4_rready_drop", m_rready, 0);
      m_rvalid = 1; m_rdata = 32'hFFFF;
      @(negedge clk);
      chk("t4_late_rready", m_rready, 0);
      chk("t4_r_hs", r_hs, 1);
      chk("t4_rsp_held", rsp_valid, 1);
      chk("t4_timeout_held", rsp_timeout, 1);
      rsp_ready = 1;
      @(negedge clk);
      m_rvalid = 0;
      chk("t4_rsp_taken", rsp_valid, 0);
      chk("t4_cmd_ready_back", cmd_ready, 1);

      // 5: back-to-back commands, rsp_ready low 5 cycles
      rsp_ready = 0;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'hCAFEF00D;
      @(negedge clk);
      cmd_write = 0; cmd_addr = 32'h44; cmd_wdata = '0;
      chk("t5_cmd_ready_busy", cmd_ready, 0);
      chk("t5_awvalid", m_awvalid, 1);
      @(negedge clk);
      chk("t5_bready", m_bready, 1);
      chk("t5_cmd_ready_busy2", cmd_ready, 0);
      m_bvalid = 1; m_bresp = 2'b00;
      @(negedge clk);
      m_bvalid = 0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_write !== 1'b1 ||
             rsp_resp !== 2'b00 || rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0) bad++;
         @(negedge clk);
      end
      chk("t5_hold_window", bad, 0);
      chk("t5_rsp_still_valid", rsp_valid, 1);
      rsp_ready = 1;
      @(negedge clk);
      chk("t5_rsp_taken", rsp_valid, 0);
      chk("t5_cmd_ready_back", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 0;
      chk("t5_arvalid", m_arvalid, 1);
      chk("t5_araddr", m_araddr, 32'h44);
      @(negedge clk);
      chk("t5_rready", m_rready, 1);
      m_rvalid = 1; m_rdata = 32'h55AA; m_rresp = 2'b00;
      @(negedge clk);
      m_rvalid = 0;
      chk("t5_rsp2_valid", rsp_valid, 1);
      chk("t5_rsp2_rdata", rsp_rdata, 32'h55AA);
      chk("t5_rsp2_write", rsp_write, 0);
      @(negedge clk);
      chk("t5_rsp2_taken", rsp_valid, 0);
      chk("t5_aw_hs", aw_hs, 3);
      chk("t5_ar_hs", ar_hs, 3);

      // 6: reset while m_awvalid is high
      m_awready = 0; m_wready = 0;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h50; cmd_wdata = 32'hAAAA;
      @(negedge clk);
      cmd_valid = 0;
      chk("t6_awvalid_pre", m_awvalid, 1);
      rst = 1'b1;
      #1;
      chk("t6_awvalid_async", m_awvalid, 0);
      chk("t6_wvalid_async", m_wvalid, 0);
      chk("t6_cmd_ready_async", cmd_ready, 0);
      chk("t6_rsp_valid_async", rsp_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      m_awready = 1; m_wready = 1;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || m_awvalid !== 1'b0 || m_wvalid !== 1'b0 ||
             m_bready !== 1'b0) bad++;
      end
      chk("t6_quiet_after_reset", bad, 0);
      chk("t6_cmd_ready", cmd_ready, 1);
      chk("t6_aw_hs", aw_hs, 3);
      chk("t6_b_hs", b_hs, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
